// File: rtl/mont_pkg.sv
// Shared types for the Montgomery multiplier and the Montgomery-transform stage.
package mont_pkg;

    localparam int MONT_WIDTH = 256;

    typedef logic [MONT_WIDTH-1:0] mont_word_t;
    typedef logic [MONT_WIDTH+1:0] mont_acc_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_CORR = 2'd2
    } mont_mult_state_t;

endpackage

// File: rtl/mont_mult_step.sv
// One radix-2 Montgomery iteration: m' = (m + a_bit*b + q*n) / 2, with q chosen so the sum is even.
module mont_mult_step
    import mont_pkg::*;
#(
    parameter int WIDTH = MONT_WIDTH
) (
    input  logic [WIDTH+1:0] m_i,
    input  logic             a_bit_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] n_i,
    output logic [WIDTH+1:0] m_o
);

    logic [WIDTH+1:0] addB;
    logic [WIDTH+1:0] sum1;
    logic [WIDTH+1:0] addN;
    logic [WIDTH+1:0] sum2;

    // With m < 2n and b < n every intermediate stays below 4n, so WIDTH+2 bits never overflow.
    always_comb begin
        addB = a_bit_i ? {2'b00, b_i} : '0;
        sum1 = m_i + addB;
        addN = sum1[0] ? {2'b00, n_i} : '0;
        sum2 = sum1 + addN;
        m_o  = sum2 >> 1;
    end

endmodule

// File: rtl/mont_mult.sv
// Bit-serial Montgomery multiplier: o_m = i_a * i_b * 2^-WIDTH mod i_n, one bit of i_a per clock.
// Optional operand checking is enabled by defining MONT_MULT_CHECK_EN.
module mont_mult
    import mont_pkg::*;
#(
    parameter int WIDTH = MONT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_n,
    output logic [WIDTH-1:0] o_m,
    output logic             o_busy,
    output logic             o_finished,
    output logic             o_err
);

    localparam logic [1:0] ST_IDLE = S_IDLE;
    localparam logic [1:0] ST_RUN  = S_RUN;
    localparam logic [1:0] ST_CORR = S_CORR;

    localparam int             CW        = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]  LAST_ITER = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH+1:0] m_q, m_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             fin_q, fin_d;

    logic [WIDTH+1:0] stepM;
    logic [WIDTH-1:0] corrDiff;
    logic             geN;
    logic             badOperands;

    mont_mult_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .m_i     (m_q),
        .a_bit_i (a_q[0]),
        .b_i     (b_q),
        .n_i     (n_q),
        .m_o     (stepM)
    );

    // The final result is below n, so the subtraction is exact modulo 2^WIDTH.
    assign geN      = (m_q >= {2'b00, n_q});
    assign corrDiff = m_q[WIDTH-1:0] - n_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        n_d     = n_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        fin_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    if (badOperands) begin
                        fin_d = 1'b1;
                    end else begin
                        a_d     = i_a;
                        b_d     = i_b;
                        n_d     = i_n;
                        m_d     = '0;
                        cnt_d   = '0;
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                // a is consumed LSB first by shifting the latched copy right each iteration.
                m_d   = stepM;
                a_d   = a_q >> 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d = ST_CORR;
                end
            end
            ST_CORR: begin
                res_d   = geN ? corrDiff : m_q[WIDTH-1:0];
                fin_d   = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            n_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            n_q     <= n_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            fin_q   <= fin_d;
        end
    end

`ifdef MONT_MULT_CHECK_EN
    logic err_q, err_d;

    // A rejected start reports through o_err and o_finished together and never leaves IDLE.
    assign badOperands = ~i_n[0] | (i_a >= i_n) | (i_b >= i_n);
    assign err_d       = (state_q == ST_IDLE) && i_start && badOperands;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign o_err = err_q;
`else
    assign badOperands = 1'b0;
    assign o_err       = 1'b0;
`endif

    assign o_m        = res_q;
    assign o_finished = fin_q;
    assign o_busy     = (state_q != ST_IDLE);

endmodule

// File: doc/mont_mult.md
Name: mont_mult

Overview:
- Bit-serial Montgomery multiplier for the RSA datapath; sits directly downstream of the Montgomery-transform stage.
- Computes o_m = i_a * i_b * 2^-WIDTH mod i_n, one operand bit per clock.
- Its operands are Montgomery-form values produced by the transform stage or fed back from itself. The exponentiation controller calls it for squaring and for multiplication.

Parameters:
- WIDTH, 256, operand/modulus width in bits; also the Montgomery exponent (R = 2^WIDTH).

Ports:
- i_clk  input  1  clock
- i_rst  input  1  synchronous active-high reset
- i_start  input  1  start request; sampled only in IDLE
- i_a  input  WIDTH  multiplicand; scanned LSB first
- i_b  input  WIDTH  multiplier
- i_n  input  WIDTH  modulus; odd, and i_a, i_b < i_n required
- o_m  output  WIDTH  result register; holds its value until the next result is written
- o_busy  output  1  high while state != IDLE
- o_finished  output  1  one-cycle pulse; o_m is valid in that cycle
- o_err  output  1  precondition-violation pulse (see Optional Feature); tied 0 when the feature is absent

Behaviour:
- Reset (i_rst=1 at a clock edge):
  - state=IDLE; o_m=0; o_finished=0; o_busy=0; o_err=0.
  - Iteration counter and accumulator cleared.
  - Applies mid-operation as well: the computation is abandoned and no o_finished is produced.
- States: IDLE, RUN, CORR.
- IDLE:
  - When i_start=1 at edge E: latch i_a, i_b, i_n into internal registers, clear accumulator m, set counter=0, go to RUN.
  - Inputs may change after E.
- RUN, edges E+1 .. E+WIDTH, iteration k = 0 .. WIDTH-1:
  - t = m + (a_latched[k] ? b : 0)
  - t = t + (t[0] ? n : 0)
  - m = t >> 1
  - counter = counter + 1
- Accumulator width:
  - m is WIDTH+2 bits; intermediate t is WIDTH+2 bits.
  - Invariant m < 2n, so no overflow is possible.
- RUN to CORR after the iteration with counter = WIDTH-1.
- CORR, edge E+WIDTH+1:
  - o_m = (m >= n) ? m - n : m, truncated to WIDTH bits.
  - o_finished=1; state goes to IDLE.
- o_finished returns to 0 at edge E+WIDTH+2, unless a new result is written there.
- Latency: o_finished is high in the cycle after edge E+WIDTH+1, i.e. WIDTH+2 edges after the start edge inclusive.
- i_start while o_busy=1 is ignored; no queuing.
- Back-to-back operation: i_start asserted during the o_finished cycle is accepted, since the state is already IDLE.
- i_start and i_rst high together: reset wins.
- Boundary values:
  - i_a=0 or i_b=0 gives o_m=0.
  - i_n = 2^WIDTH-1 must work; this exercises the full accumulator width.
- Results for even i_n or out-of-range operands are undefined unless the Optional Feature is enabled.

Optional Feature:
- Macro: MONT_MULT_CHECK_EN.
- Enabled:
  - On an accepted i_start (edge E), if i_n[0]==0, or i_a>=i_n, or i_b>=i_n: no RUN is performed, and state stays IDLE.
  - At edge E, o_err=1 and o_finished=1 are set; both are high for exactly the following cycle.
  - o_m is unchanged.
  - A valid start behaves exactly as without the macro; o_err stays 0.
- Disabled: no operand checks; o_err is constant 0.

Decomposition:
- Package mont_pkg:
  - localparam MONT_WIDTH = 256
  - typedef mont_word_t: logic [MONT_WIDTH-1:0]
  - typedef mont_acc_t: logic [MONT_WIDTH+1:0]
  - typedef enum mont_mult_state_t: {S_IDLE, S_RUN, S_CORR}
  - The transform stage uses the same package.
- Sub-module mont_mult_step: purely combinational single iteration (m, a_bit, b, n) -> next m. Instantiated once; reusable by a future radix-4 variant.

Test Plan:
- WIDTH=8, n=13, a=5, b=7, start pulse -> o_finished exactly 10 edges after the start edge; o_m=1; o_busy high for 9 cycles.
- WIDTH=8, n=13, a=1, b=1 -> o_m=3. Second start issued in the o_finished cycle with a=0, b=9 -> accepted; o_m=0 after a further 10 edges.
- WIDTH=8, n=255, a=254, b=254 -> o_m=1 (full-width accumulator path); a=254, b=1 -> o_m=254.
- WIDTH=256: a = 2^256 mod n (the transform-stage output for 1), b = random x < n, random odd n -> o_m = x.
- Fault injections:
  - Mid-run reset (i_rst at RUN iteration 100) -> all outputs 0 next cycle, no o_finished; a subsequent start completes normally.
  - i_start toggled during RUN -> ignored, and the result equals the golden model.
- With MONT_MULT_CHECK_EN, WIDTH=8:
  - n=12 -> o_err=1 and o_finished=1 in the cycle after start; o_m unchanged; o_busy stays 0.
  - n=13, a=13 -> same response.
